// File: rtl/snake_pkg.sv
// Shared snake-game definitions: placer state encoding, LFSR geometry and default grid size.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_CHECK,
    ST_COMMIT,
    ST_FAIL
  } place_state_t;

  localparam int          LFSR_W    = 16;
  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam int DEFAULT_XSIZE   = 48;
  localparam int DEFAULT_YSIZE   = 64;
  localparam int DEFAULT_COORD_W = 6;

endpackage

// File: rtl/snake_lfsr.sv
// Free-running Fibonacci LFSR; shifts left every clock, feedback enters at bit 0.
module snake_lfsr
  import snake_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  output logic [WIDTH-1:0] lfsr
);

  logic [WIDTH-1:0] lfsr_reg;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) lfsr_reg <= SEED;
    else        lfsr_reg <= {lfsr_reg[WIDTH-2:0], ^(lfsr_reg & TAPS)};
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/snake_item_placer.sv
// Multi-slot item placer: draws random cells until one is clear of the snake body and of the
// other live items, then commits it to the requested slot.
module snake_item_placer
  import snake_pkg::*;
#(
  parameter int          XSIZE     = DEFAULT_XSIZE,
  parameter int          YSIZE     = DEFAULT_YSIZE,
  parameter int          COORD_W   = DEFAULT_COORD_W,
  parameter int          MAX_BODY  = 20,
  parameter int          NUM_ITEMS = 4,
  parameter int          MAX_TRIES = 255,
  parameter logic [15:0] SEED      = LFSR_SEED,
  localparam int         SLOT_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Req,
  input  logic [SLOT_W-1:0]            i_Slot,
  input  logic                         i_Clear,
  input  logic [MAX_BODY*COORD_W-1:0]  i_Body_x,
  input  logic [MAX_BODY*COORD_W-1:0]  i_Body_y,
  input  logic [11:0]                  i_Body_size,
  output logic [NUM_ITEMS*COORD_W-1:0] o_Items_x,
  output logic [NUM_ITEMS*COORD_W-1:0] o_Items_y,
  output logic [NUM_ITEMS-1:0]         o_Valid,
  output logic                         o_Busy,
  output logic                         o_Done,
  output logic                         o_Fail
);

  localparam int IDX_W = $clog2(MAX_BODY + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [LFSR_W-1:0]    lfsr;
  logic                 unused_lfsr;
  logic [COORD_W-1:0]   raw_x, raw_y;
  logic                 raw_in_grid;

  place_state_t         state_reg, state_next;
  logic [SLOT_W-1:0]    slot_reg, slot_next;
  logic [TRY_W-1:0]     tries_reg, tries_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [COORD_W-1:0]   cand_x_reg, cand_x_next;
  logic [COORD_W-1:0]   cand_y_reg, cand_y_next;

  logic [COORD_W-1:0]   items_x_reg [NUM_ITEMS];
  logic [COORD_W-1:0]   items_y_reg [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] valid_reg;

  logic [MAX_BODY-1:0]  seg_hit;
  logic [NUM_ITEMS-1:0] item_hit, slot_clear, slot_commit;
  logic [11:0]          body_n;
  logic                 body_hit, slot_in_range;

  snake_lfsr #(.WIDTH(LFSR_W), .SEED(SEED)) u_lfsr (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .lfsr  (lfsr)
  );

  assign raw_x       = lfsr[COORD_W-1:0];
  assign raw_y       = lfsr[2*COORD_W-1:COORD_W];
  assign unused_lfsr = ^lfsr[LFSR_W-1:2*COORD_W];
  assign raw_in_grid = (32'(raw_x) < XSIZE) && (32'(raw_y) < YSIZE);
  assign body_n      = (i_Body_size > 12'(MAX_BODY)) ? 12'(MAX_BODY) : i_Body_size;

  genvar gi;
  generate
    if (NUM_ITEMS == (1 << SLOT_W)) begin : g_slot_full
      assign slot_in_range = 1'b1;
    end else begin : g_slot_part
      assign slot_in_range = (32'(i_Slot) < NUM_ITEMS);
    end

    for (gi = 0; gi < MAX_BODY; gi++) begin : g_seg
      assign seg_hit[gi] = (i_Body_x[gi*COORD_W +: COORD_W] == cand_x_reg) &&
                           (i_Body_y[gi*COORD_W +: COORD_W] == cand_y_reg);
    end

    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_slot
      // The target slot never blocks its own replacement
      assign item_hit[gi]    = valid_reg[gi] && (slot_reg != SLOT_W'(gi)) &&
                               (items_x_reg[gi] == cand_x_reg) && (items_y_reg[gi] == cand_y_reg);
      assign slot_clear[gi]  = i_Clear && (i_Slot == SLOT_W'(gi));
      assign slot_commit[gi] = (state_reg == ST_COMMIT) && (slot_reg == SLOT_W'(gi));
      assign o_Items_x[gi*COORD_W +: COORD_W] = items_x_reg[gi];
      assign o_Items_y[gi*COORD_W +: COORD_W] = items_y_reg[gi];
    end
  endgenerate

  always_comb begin
    body_hit = 1'b0;
    for (int k = 0; k < MAX_BODY; k++) begin
      if ((k == int'(idx_reg)) && (12'(k) < body_n)) body_hit = seg_hit[k];
    end
  end

  always_comb begin
    state_next  = state_reg;
    slot_next   = slot_reg;
    tries_next  = tries_reg;
    idx_next    = idx_reg;
    cand_x_next = cand_x_reg;
    cand_y_next = cand_y_reg;
    o_Busy      = (state_reg != ST_IDLE);
    o_Done      = 1'b0;
    o_Fail      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_Req && slot_in_range) begin
          slot_next  = i_Slot;
          tries_next = '0;
          state_next = ST_DRAW;
        end
      end
      ST_DRAW: begin
        cand_x_next = raw_x;
        cand_y_next = raw_y;
        tries_next  = tries_reg + TRY_W'(1);
        idx_next    = '0;
        if (!raw_in_grid) state_next = (32'(tries_next) >= MAX_TRIES) ? ST_FAIL : ST_DRAW;
        else              state_next = ST_CHECK;
      end
      ST_CHECK: begin
        // Other items are only compared on the first body cycle
        if (body_hit || ((idx_reg == '0) && (|item_hit))) begin
          state_next = (32'(tries_reg) >= MAX_TRIES) ? ST_FAIL : ST_DRAW;
        end else if ((12'(idx_reg) + 12'd1) >= body_n) begin
          state_next = ST_COMMIT;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        o_Done     = 1'b1;
        state_next = ST_IDLE;
      end
      ST_FAIL: begin
        o_Fail     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_reg  <= ST_IDLE;
      slot_reg   <= '0;
      tries_reg  <= '0;
      idx_reg    <= '0;
      cand_x_reg <= '0;
      cand_y_reg <= '0;
    end else begin
      state_reg  <= state_next;
      slot_reg   <= slot_next;
      tries_reg  <= tries_next;
      idx_reg    <= idx_next;
      cand_x_reg <= cand_x_next;
      cand_y_reg <= cand_y_next;
    end
  end

  // A commit to the same slot lands after the clear, so it wins
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      valid_reg <= '0;
      for (int k = 0; k < NUM_ITEMS; k++) begin
        items_x_reg[k] <= '0;
        items_y_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
        if (slot_clear[k]) valid_reg[k] <= 1'b0;
        if (slot_commit[k]) begin
          valid_reg[k]   <= 1'b1;
          items_x_reg[k] <= cand_x_reg;
          items_y_reg[k] <= cand_y_reg;
        end
      end
    end
  end

  assign o_Valid = valid_reg;

endmodule

// File: tb/tb_snake_item_placer.sv
// Directed bench for snake_item_placer: default 48x64 grid plus two 4x4 grids (normal and 8-try).
module tb_snake_item_placer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default configuration
  logic         rst_d, req_d, clr_d, busy_d, done_d, fail_d;
  logic [1:0]   slot_d;
  logic [119:0] bx_d, by_d;
  logic [11:0]  bsz_d;
  logic [23:0]  ix_d, iy_d;
  logic [3:0]   val_d;

  // 4x4 grid, default retry limit
  logic         rst_a, req_a, clr_a, busy_a, done_a, fail_a;
  logic [1:0]   slot_a;
  logic [31:0]  bx_a, by_a;
  logic [11:0]  bsz_a;
  logic [7:0]   ix_a, iy_a;
  logic [3:0]   val_a;

  // 4x4 grid, 8 tries
  logic         rst_b, req_b, clr_b, busy_b, done_b, fail_b;
  logic [1:0]   slot_b;
  logic [31:0]  bx_b, by_b;
  logic [11:0]  bsz_b;
  logic [7:0]   ix_b, iy_b;
  logic [3:0]   val_b;

  snake_item_placer dut_d (
    .i_Clk(clk), .i_Rst(rst_d), .i_Req(req_d), .i_Slot(slot_d), .i_Clear(clr_d),
    .i_Body_x(bx_d), .i_Body_y(by_d), .i_Body_size(bsz_d),
    .o_Items_x(ix_d), .o_Items_y(iy_d), .o_Valid(val_d),
    .o_Busy(busy_d), .o_Done(done_d), .o_Fail(fail_d)
  );

  snake_item_placer #(.XSIZE(4), .YSIZE(4), .COORD_W(2), .MAX_BODY(16)) dut_a (
    .i_Clk(clk), .i_Rst(rst_a), .i_Req(req_a), .i_Slot(slot_a), .i_Clear(clr_a),
    .i_Body_x(bx_a), .i_Body_y(by_a), .i_Body_size(bsz_a),
    .o_Items_x(ix_a), .o_Items_y(iy_a), .o_Valid(val_a),
    .o_Busy(busy_a), .o_Done(done_a), .o_Fail(fail_a)
  );

  snake_item_placer #(.XSIZE(4), .YSIZE(4), .COORD_W(2), .MAX_BODY(16), .MAX_TRIES(8)) dut_b (
    .i_Clk(clk), .i_Rst(rst_b), .i_Req(req_b), .i_Slot(slot_b), .i_Clear(clr_b),
    .i_Body_x(bx_b), .i_Body_y(by_b), .i_Body_size(bsz_b),
    .o_Items_x(ix_b), .o_Items_y(iy_b), .o_Valid(val_b),
    .o_Busy(busy_b), .o_Done(done_b), .o_Fail(fail_b)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSRs, built from the seed and tap list, one per reset domain that needs prediction
  logic [15:0] m_d, m_b;
  always @(posedge clk or negedge rst_d) begin
    if (!rst_d) m_d <= 16'hACE1;
    else        m_d <= lfsr_step(m_d);
  end
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) m_b <= 16'hACE1;
    else        m_b <= lfsr_step(m_b);
  end

  // 4x4 body listing every cell k = y*4+x in ascending order, skipping cells flagged in excl
  task automatic build_body(input logic [15:0] excl, output logic [31:0] bx,
                            output logic [31:0] by, output logic [11:0] n);
    int c;
    c  = 0;
    bx = '0;
    by = '0;
    for (int k = 0; k < 16; k++) begin
      if (!excl[k]) begin
        bx[c*2 +: 2] = 2'(k);
        by[c*2 +: 2] = 2'(k >> 2);
        c++;
      end
    end
    n = 12'(c);
  endtask

  // Wait until the value the LFSR will hold in the DRAW cycle has x < 48
  task automatic wait_in_range(output logic [15:0] nxt);
    nxt = lfsr_step(m_d);
    for (int i = 0; i < 64 && nxt[5:0] >= 6'd48; i++) begin
      @(negedge clk);
      nxt = lfsr_step(m_d);
    end
  endtask

  task automatic run_req_a(input logic [1:0] slot, output logic done_seen);
    logic ended;
    req_a = 1'b1;
    slot_a = slot;
    done_seen = 1'b0;
    ended = 1'b0;
    for (int i = 1; i <= 5000 && !ended; i++) begin
      @(negedge clk);
      req_a = 1'b0;
      if (done_a) done_seen = 1'b1;
      if (done_a || fail_a) ended = 1'b1;
    end
    @(negedge clk);
    $display("req a slot%0d: done=%0b valid=%b", slot, done_seen, val_a);
  endtask

  task automatic test_reset();
    rst_d = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    req_d = 1'b0; clr_d = 1'b0; slot_d = '0; bx_d = '0; by_d = '0; bsz_d = '0;
    req_a = 1'b0; clr_a = 1'b0; slot_a = '0; bx_a = '0; by_a = '0; bsz_a = '0;
    req_b = 1'b0; clr_b = 1'b0; slot_b = '0; bx_b = '0; by_b = '0; bsz_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_d, done_d, fail_d} !== 3'b000) begin
      failures++; $display("FAIL reset_flags_d: got %b expected 000", {busy_d, done_d, fail_d});
    end
    checks++;
    if (val_d !== 4'b0000) begin
      failures++; $display("FAIL reset_valid_d: got %b expected 0000", val_d);
    end
    checks++;
    if ({ix_d, iy_d} !== 48'd0) begin
      failures++; $display("FAIL reset_items_d: got %h expected 0", {ix_d, iy_d});
    end
    checks++;
    if ({val_a, busy_a, done_a, fail_a} !== 7'd0) begin
      failures++; $display("FAIL reset_a: got %b expected 0000000", {val_a, busy_a, done_a, fail_a});
    end
    checks++;
    if ({val_b, busy_b, done_b, fail_b} !== 7'd0) begin
      failures++; $display("FAIL reset_b: got %b expected 0000000", {val_b, busy_b, done_b, fail_b});
    end
    rst_d = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({val_d, busy_d, done_d, fail_d} !== 7'd0) begin
      failures++; $display("FAIL idle_after_release: got %b expected 0000000", {val_d, busy_d, done_d, fail_d});
    end
    $display("reset: released");
  endtask

  task automatic test_empty_body();
    logic [15:0] nxt;
    int          done_at;
    logic        busy1, busy4;
    bsz_d = 12'd0;
    wait_in_range(nxt);
    req_d = 1'b1;
    slot_d = 2'd0;
    done_at = 0; busy1 = 1'b0; busy4 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req_d = 1'b0;
      if (done_d && done_at == 0) done_at = i;
      if (i == 1) busy1 = busy_d;
      if (i == 4) busy4 = busy_d;
    end
    $display("req d slot0 empty body: done at %0d item (%0d,%0d)", done_at, ix_d[5:0], iy_d[5:0]);
    checks++;
    if (done_at != 3) begin
      failures++; $display("FAIL empty_latency: got %0d expected 3", done_at);
    end
    checks++;
    if (busy1 !== 1'b1) begin
      failures++; $display("FAIL empty_busy_draw: got %b expected 1", busy1);
    end
    checks++;
    if (busy4 !== 1'b0) begin
      failures++; $display("FAIL empty_busy_after_done: got %b expected 0", busy4);
    end
    checks++;
    if (val_d !== 4'b0001) begin
      failures++; $display("FAIL empty_valid: got %b expected 0001", val_d);
    end
    checks++;
    if (ix_d[5:0] !== nxt[5:0]) begin
      failures++; $display("FAIL empty_x: got %0d expected %0d", ix_d[5:0], nxt[5:0]);
    end
    checks++;
    if (iy_d[5:0] !== nxt[11:6]) begin
      failures++; $display("FAIL empty_y: got %0d expected %0d", iy_d[5:0], nxt[11:6]);
    end
  endtask

  task automatic test_busy_ignored();
    logic [15:0] nxt;
    int          done_at;
    wait_in_range(nxt);
    req_d = 1'b1;
    slot_d = 2'd1;
    done_at = 0;
    for (int i = 1; i <= 300 && done_at == 0; i++) begin
      @(negedge clk);
      if (i == 1) slot_d = 2'd2;
      if (i == 3) req_d = 1'b0;
      if (done_d) done_at = i;
    end
    req_d = 1'b0;
    @(negedge clk);
    $display("req d slot1 with slot2 request while busy: done at %0d", done_at);
    checks++;
    if (done_at == 0) begin
      failures++; $display("FAIL busy_req_done: got timeout expected o_Done");
    end
    checks++;
    if (busy_d !== 1'b0) begin
      failures++; $display("FAIL busy_req_idle: got %b expected 0", busy_d);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (val_d !== 4'b0011) begin
      failures++; $display("FAIL busy_req_valid: got %b expected 0011", val_d);
    end
    checks++;
    if (busy_d !== 1'b0) begin
      failures++; $display("FAIL busy_req_not_restarted: got %b expected 0", busy_d);
    end
  endtask

  task automatic test_reset_mid_check();
    logic [15:0] nxt;
    int          pulses;
    logic        busy_seen;
    bx_d = '1;
    by_d = '1;
    bsz_d = 12'd20;
    wait_in_range(nxt);
    req_d = 1'b1;
    slot_d = 2'd2;
    @(negedge clk);
    req_d = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_d !== 1'b1) begin
      failures++; $display("FAIL midreset_busy_before: got %b expected 1", busy_d);
    end
    rst_d = 1'b0;
    #1;
    checks++;
    if ({val_d, busy_d, done_d, fail_d} !== 7'd0) begin
      failures++; $display("FAIL midreset_outputs: got %b expected 0000000", {val_d, busy_d, done_d, fail_d});
    end
    @(negedge clk);
    rst_d = 1'b1;
    pulses = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_d || fail_d) pulses++;
      if (busy_d) busy_seen = 1'b1;
    end
    $display("reset mid-check: pulses after release %0d", pulses);
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL midreset_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (busy_seen !== 1'b0 || val_d !== 4'b0000) begin
      failures++; $display("FAIL midreset_idle: got busy=%b valid=%b expected busy=0 valid=0000", busy_seen, val_d);
    end
  endtask

  task automatic test_single_free();
    logic done_seen;
    build_body(16'h4000, bx_a, by_a, bsz_a);
    run_req_a(2'd0, done_seen);
    checks++;
    if (done_seen !== 1'b1) begin
      failures++; $display("FAIL single_free_done: got %b expected 1", done_seen);
    end
    checks++;
    if ({ix_a[1:0], iy_a[1:0]} !== {2'd2, 2'd3}) begin
      failures++; $display("FAIL single_free_item: got (%0d,%0d) expected (2,3)", ix_a[1:0], iy_a[1:0]);
    end
    checks++;
    if (val_a !== 4'b0001) begin
      failures++; $display("FAIL single_free_valid: got %b expected 0001", val_a);
    end
  endtask

  task automatic test_no_duplicate();
    logic done_seen;
    build_body(16'h0020, bx_a, by_a, bsz_a);
    run_req_a(2'd1, done_seen);
    checks++;
    if (done_seen !== 1'b1 || {ix_a[3:2], iy_a[3:2]} !== {2'd1, 2'd1}) begin
      failures++; $display("FAIL slot1_item: got done=%b (%0d,%0d) expected done=1 (1,1)", done_seen, ix_a[3:2], iy_a[3:2]);
    end
    clr_a = 1'b1;
    slot_a = 2'd0;
    @(negedge clk);
    clr_a = 1'b0;
    $display("clear a slot0: valid=%b", val_a);
    checks++;
    if (val_a !== 4'b0010) begin
      failures++; $display("FAIL clear_slot0: got %b expected 0010", val_a);
    end
    build_body(16'h0021, bx_a, by_a, bsz_a);
    run_req_a(2'd0, done_seen);
    checks++;
    if (done_seen !== 1'b1 || {ix_a[1:0], iy_a[1:0]} !== {2'd0, 2'd0}) begin
      failures++; $display("FAIL no_dup_item: got done=%b (%0d,%0d) expected done=1 (0,0)", done_seen, ix_a[1:0], iy_a[1:0]);
    end
    checks++;
    if ({ix_a[3:2], iy_a[3:2]} !== {2'd1, 2'd1} || val_a !== 4'b0011) begin
      failures++; $display("FAIL no_dup_slot1: got (%0d,%0d) valid=%b expected (1,1) valid=0011", ix_a[3:2], iy_a[3:2], val_a);
    end
    clr_a = 1'b1;
    slot_a = 2'd1;
    @(negedge clk);
    clr_a = 1'b0;
    $display("clear a slot1: valid=%b", val_a);
    checks++;
    if (val_a !== 4'b0001) begin
      failures++; $display("FAIL clear_slot1: got %b expected 0001", val_a);
    end
  endtask

  task automatic test_fail_exhausted();
    logic [15:0] lv;
    int          t, k, fail_t, fail_first, fail_count;
    logic        done_any, busy_after;
    build_body(16'h0000, bx_b, by_b, bsz_b);
    // Full body in cell order: a candidate from lfsr[3:0] hits at segment index lfsr[3:0]
    lv = lfsr_step(m_b);
    t = 1;
    fail_t = 0;
    for (int d = 0; d < 8; d++) begin
      k = int'(lv[3:0]);
      if (d == 7) begin
        fail_t = t + k + 2;
      end else begin
        t = t + k + 2;
        for (int s = 0; s < k + 2; s++) lv = lfsr_step(lv);
      end
    end
    req_b = 1'b1;
    slot_b = 2'd0;
    fail_first = 0; fail_count = 0; done_any = 1'b0; busy_after = 1'b1;
    for (int i = 1; i <= fail_t + 1; i++) begin
      @(negedge clk);
      req_b = 1'b0;
      if (fail_b) begin
        fail_count++;
        if (fail_first == 0) fail_first = i;
      end
      if (done_b) done_any = 1'b1;
      if (i == fail_t + 1) busy_after = busy_b;
    end
    $display("req b slot0 full body: gave up at cycle %0d (predicted %0d)", fail_first, fail_t);
    checks++;
    if (fail_first != fail_t) begin
      failures++; $display("FAIL exhaust_cycle: got %0d expected %0d", fail_first, fail_t);
    end
    checks++;
    if (fail_count != 1 || done_any !== 1'b0) begin
      failures++; $display("FAIL exhaust_pulses: got fail=%0d done=%b expected fail=1 done=0", fail_count, done_any);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++; $display("FAIL exhaust_busy_after: got %b expected 0", busy_after);
    end
    checks++;
    if (val_b !== 4'b0000) begin
      failures++; $display("FAIL exhaust_valid: got %b expected 0000", val_b);
    end
  endtask

  initial begin
    test_reset();
    test_empty_body();
    test_busy_ignored();
    test_reset_mid_check();
    test_single_free();
    test_no_duplicate();
    test_fail_exhausted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
